// File: rtl/demux_1_2_32bit.sv
// Registered 1:2 word router: one valid/ready source steered by `select` into two DEPTH-entry FIFOs.
// Latency 1 cycle in->out; in_ready depends only on select and the registered full flags. Optional DEMUX_COUNT_EN adds pop counters.

module demux_1_2_32bit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic             full
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0] ONE      = (AW+1)'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [AW:0]      cnt_q, cnt_d;
    logic             full_q, full_d;
    logic             empty_q, empty_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic [WIDTH-1:0] head;
    logic             pop;

    assign pop    = !empty_q && rd_rdy;
    // While empty, the port keeps showing the last word it presented.
    assign head   = empty_q ? hold_q : mem_q[rd_ptr_q[AW-1:0]];
    assign rd_dat = head;
    assign rd_vld = !empty_q;
    assign full   = full_q;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        hold_d   = head;
        if (push) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_dat;
            wr_ptr_d                = wr_ptr_q + ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + ONE;
        end
        case ({push, pop})
            2'b10:   cnt_d = cnt_q + ONE;
            2'b01:   cnt_d = cnt_q - ONE;
            default: cnt_d = cnt_q;
        endcase
        full_d  = (cnt_d == FULL_CNT);
        empty_d = (cnt_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            hold_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            hold_q   <= hold_d;
        end
    end

    // Storage needs no reset: an empty FIFO never exposes it.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

module demux_1_2_32bit #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             select,
    output logic             out1_valid,
    input  logic             out1_ready,
    output logic [WIDTH-1:0] out1_data,
    output logic             out2_valid,
    input  logic             out2_ready,
    output logic [WIDTH-1:0] out2_data,
    output logic [15:0]      out1_count,
    output logic [15:0]      out2_count
);
    logic full1, full2;
    logic push1, push2;

    assign in_ready = select ? !full2 : !full1;
    assign push1    = in_valid && in_ready && !select;
    assign push2    = in_valid && in_ready &&  select;

    demux_1_2_32bit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo1 (
        .clk    (clk),
        .reset  (reset),
        .push   (push1),
        .wr_dat (in_data),
        .rd_rdy (out1_ready),
        .rd_vld (out1_valid),
        .rd_dat (out1_data),
        .full   (full1)
    );

    demux_1_2_32bit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo2 (
        .clk    (clk),
        .reset  (reset),
        .push   (push2),
        .wr_dat (in_data),
        .rd_rdy (out2_ready),
        .rd_vld (out2_valid),
        .rd_dat (out2_data),
        .full   (full2)
    );

`ifdef DEMUX_COUNT_EN
    logic        pop1, pop2;
    logic [15:0] cnt1_q, cnt1_d;
    logic [15:0] cnt2_q, cnt2_d;

    assign pop1 = out1_valid && out1_ready;
    assign pop2 = out2_valid && out2_ready;

    // Saturating delivery counters.
    always_comb begin
        cnt1_d = cnt1_q;
        cnt2_d = cnt2_q;
        if (pop1 && (cnt1_q != 16'hFFFF)) cnt1_d = cnt1_q + 16'd1;
        if (pop2 && (cnt2_q != 16'hFFFF)) cnt2_d = cnt2_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt1_q <= '0;
            cnt2_q <= '0;
        end else begin
            cnt1_q <= cnt1_d;
            cnt2_q <= cnt2_d;
        end
    end

    assign out1_count = cnt1_q;
    assign out2_count = cnt2_q;
`else
    assign out1_count = 16'h0000;
    assign out2_count = 16'h0000;
`endif
endmodule

// File: tb/tb_demux_1_2_32bit.sv
// Bench for demux_1_2_32bit: directed scenarios plus random traffic checked against a queue model.
module tb_demux_1_2_32bit;
    localparam int WIDTH = 32;
    localparam int DEPTH = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [WIDTH-1:0] in_data = '0;
    logic             select = 1'b0;
    logic             out1_valid, out2_valid;
    logic             out1_ready = 1'b0, out2_ready = 1'b0;
    logic [WIDTH-1:0] out1_data, out2_data;
    logic [15:0]      out1_count, out2_count;

    int n_chk = 0;
    int n_fail = 0;

    // Behavioural model: one queue per stream, last delivered word, delivery counts.
    logic [WIDTH-1:0] q1[$], q2[$];
    logic [WIDTH-1:0] last1 = '0, last2 = '0;
    int m1 = 0, m2 = 0;

    demux_1_2_32bit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .select(select),
        .out1_valid(out1_valid), .out1_ready(out1_ready), .out1_data(out1_data),
        .out2_valid(out2_valid), .out2_ready(out2_ready), .out2_data(out2_data),
        .out1_count(out1_count), .out2_count(out2_count)
    );

    always #5 clk = ~clk;

    function automatic bit model_rdy();
        return select ? (q2.size() < DEPTH) : (q1.size() < DEPTH);
    endfunction

    function automatic int exp_count(int m);
`ifdef DEMUX_COUNT_EN
        return m;
`else
        return 0;
`endif
    endfunction

    // Advance one clock edge and apply the same edge to the model.
    task automatic tick();
        bit acc, p1, p2;
        acc = in_valid && model_rdy();
        p1  = (q1.size() > 0) && out1_ready;
        p2  = (q2.size() > 0) && out2_ready;
        @(posedge clk);
        if (reset) begin
            q1.delete(); q2.delete();
            last1 = '0; last2 = '0; m1 = 0; m2 = 0;
        end else begin
            if (p1) begin last1 = q1.pop_front(); if (m1 < 65535) m1++; end
            if (p2) begin last2 = q2.pop_front(); if (m2 < 65535) m2++; end
            if (acc) begin
                if (select) q2.push_back(in_data); else q1.push_back(in_data);
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b1; in_data = 32'hDEADBEEF; select = 1'b0;
        out1_ready = 1'b0; out2_ready = 1'b0;
        tick(); tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        n_chk++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_valid: got %b/%b want 0/0", out1_valid, out2_valid); end
        n_chk++; if (out1_data !== '0 || out2_data !== '0) begin n_fail++;
            $display("FAIL reset_data: got %h/%h want 0/0", out1_data, out2_data); end
        n_chk++; if (out1_count !== 16'd0 || out2_count !== 16'd0) begin n_fail++;
            $display("FAIL reset_count: got %0d/%0d want 0/0", out1_count, out2_count); end
        n_chk++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_rdy_sel0: got %b want 1", in_ready); end
        select = 1'b1; #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_rdy_sel1: got %b want 1", in_ready); end
        tick();
        n_chk++; if (out1_valid !== 1'b0 || out2_valid !== 1'b0) begin n_fail++;
            $display("FAIL reset_no_capture: got %b/%b want 0/0", out1_valid, out2_valid); end
    endtask

    task automatic test_basic_routing();
        out1_ready = 1'b1; out2_ready = 1'b1;
        in_valid = 1'b1; select = 1'b0; in_data = 32'h55555AAA; #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL route_rdy1: got %b want 1", in_ready); end
        tick();
        n_chk++; if (out1_valid !== 1'b1 || out1_data !== 32'h55555AAA) begin n_fail++;
            $display("FAIL route_out1: got %b %h want 1 55555aaa", out1_valid, out1_data); end
        n_chk++; if (out2_valid !== 1'b0) begin n_fail++;
            $display("FAIL route_out2_quiet: got %b want 0", out2_valid); end
        select = 1'b1; in_data = 32'hFFFFFFFF; #1;
        tick();
        n_chk++; if (out2_valid !== 1'b1 || out2_data !== 32'hFFFFFFFF) begin n_fail++;
            $display("FAIL route_out2: got %b %h want 1 ffffffff", out2_valid, out2_data); end
        n_chk++; if (out1_valid !== 1'b0) begin n_fail++;
            $display("FAIL route_out1_quiet: got %b want 0", out1_valid); end
        in_valid = 1'b0;
        tick();
        n_chk++; if (out2_valid !== 1'b0) begin n_fail++;
            $display("FAIL route_out2_drain: got %b want 0", out2_valid); end
    endtask

    task automatic test_backpressure();
        out1_ready = 1'b0; out2_ready = 1'b1;
        in_valid = 1'b1; select = 1'b0;
        in_data = 32'hA0000001; tick();
        in_data = 32'hA0000002; tick();
        in_data = 32'hA0000003; #1;
        n_chk++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_third_blocked: got %b want 0", in_ready); end
        tick();
        n_chk++; if (in_ready !== 1'b0) begin n_fail++;
            $display("FAIL bp_still_blocked: got %b want 0", in_ready); end
        select = 1'b1; in_data = 32'hB0000001; #1;
        n_chk++; if (in_ready !== 1'b1) begin n_fail++;
            $display("FAIL bp_out2_accept: got %b want 1", in_ready); end
        tick();
        n_chk++; if (out2_valid !== 1'b1 || out2_data !== 32'hB0000001) begin n_fail++;
            $display("FAIL bp_out2_data: got %b %h want 1 b0000001", out2_valid, out2_data); end
        select = 1'b0; in_data = 32'hA0000003; out1_ready = 1'b1; #1;
        n_chk++; if (in_ready !== 1'b0 || out1_data !== 32'hA0000001) begin n_fail++;
            $display("FAIL bp_no_passthru: got rdy %b head %h want 0 a0000001", in_ready, out1_data); end
        tick();
        n_chk++; if (in_ready !== 1'b1 || out1_data !== 32'hA0000002) begin n_fail++;
            $display("FAIL bp_pop1: got rdy %b head %h want 1 a0000002", in_ready, out1_data); end
        tick();
        in_valid = 1'b0;
        n_chk++; if (out1_valid !== 1'b1 || out1_data !== 32'hA0000003) begin n_fail++;
            $display("FAIL bp_third_head: got %b %h want 1 a0000003", out1_valid, out1_data); end
        tick();
        n_chk++; if (out1_valid !== 1'b0 || out1_data !== 32'hA0000003) begin n_fail++;
            $display("FAIL bp_drained: got %b %h want 0 a0000003", out1_valid, out1_data); end
    endtask

    task automatic test_stream_wrap();
        out2_ready = 1'b1; select = 1'b1; in_valid = 1'b1;
        for (int i = 1; i <= 10; i++) begin
            in_data = WIDTH'(i); #1;
            n_chk++; if (in_ready !== 1'b1) begin n_fail++;
                $display("FAIL wrap_rdy[%0d]: got %b want 1", i, in_ready); end
            tick();
            n_chk++; if (out2_valid !== 1'b1 || out2_data !== WIDTH'(i)) begin n_fail++;
                $display("FAIL wrap_data[%0d]: got %b %h want 1 %h", i, out2_valid, out2_data, i); end
        end
        in_valid = 1'b0;
        tick();
        n_chk++; if (out2_valid !== 1'b0) begin n_fail++;
            $display("FAIL wrap_end: got %b want 0", out2_valid); end
    endtask

    task automatic test_reset_mid();
        out1_ready = 1'b0; select = 1'b0; in_valid = 1'b1;
        in_data = 32'h11; tick();
        in_data = 32'h22; tick();
        in_valid = 1'b0; reset = 1'b1; out1_ready = 1'b1;
        tick();
        reset = 1'b0; #1;
        n_chk++; if (out1_valid !== 1'b0 || out1_data !== '0 || out1_count !== 16'd0) begin n_fail++;
            $display("FAIL mid_reset: got %b %h %0d want 0 0 0", out1_valid, out1_data, out1_count); end
        in_valid = 1'b1; in_data = 32'h33; tick();
        n_chk++; if (out1_valid !== 1'b1 || out1_data !== 32'h33) begin n_fail++;
            $display("FAIL mid_fresh1: got %b %h want 1 33", out1_valid, out1_data); end
        in_data = 32'h44; tick();
        in_valid = 1'b0;
        n_chk++; if (out1_valid !== 1'b1 || out1_data !== 32'h44) begin n_fail++;
            $display("FAIL mid_fresh2: got %b %h want 1 44", out1_valid, out1_data); end
        tick();
    endtask

    task automatic test_counters();
        logic [15:0] e1, e2;
        reset = 1'b1; in_valid = 1'b0; tick(); reset = 1'b0;
        out1_ready = 1'b1; out2_ready = 1'b1; in_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            select = (i >= 5); in_data = $urandom; tick();
        end
        in_valid = 1'b0; tick(); tick();
`ifdef DEMUX_COUNT_EN
        e1 = 16'd5; e2 = 16'd3;
`else
        e1 = 16'd0; e2 = 16'd0;
`endif
        n_chk++; if (out1_count !== e1 || out2_count !== e2) begin n_fail++;
            $display("FAIL counters: got %0d/%0d want %0d/%0d", out1_count, out2_count, e1, e2); end
    endtask

    task automatic test_random();
        bit accepted, was_reset;
        logic [WIDTH-1:0] e1, e2;
        reset = 1'b0; in_valid = 1'b0;
        for (int c = 0; c < 600; c++) begin
            #1;
            e1 = (q1.size() > 0) ? q1[0] : last1;
            e2 = (q2.size() > 0) ? q2[0] : last2;
            n_chk++; if (in_ready !== model_rdy()) begin n_fail++;
                $display("FAIL rnd_rdy c%0d: got %b want %b", c, in_ready, model_rdy()); end
            n_chk++; if (out1_valid !== (q1.size() > 0) || out2_valid !== (q2.size() > 0)) begin n_fail++;
                $display("FAIL rnd_valid c%0d: got %b/%b want %b/%b", c, out1_valid, out2_valid,
                         q1.size() > 0, q2.size() > 0); end
            n_chk++; if (out1_data !== e1 || out2_data !== e2) begin n_fail++;
                $display("FAIL rnd_data c%0d: got %h/%h want %h/%h", c, out1_data, out2_data, e1, e2); end
            n_chk++; if (out1_count !== 16'(exp_count(m1)) || out2_count !== 16'(exp_count(m2))) begin n_fail++;
                $display("FAIL rnd_count c%0d: got %0d/%0d want %0d/%0d", c, out1_count, out2_count,
                         exp_count(m1), exp_count(m2)); end
            accepted  = in_valid && model_rdy();
            was_reset = reset;
            tick();
            if (was_reset || !in_valid || accepted) begin
                in_valid = ($urandom_range(3) != 0);
                select   = $urandom_range(1);
                in_data  = $urandom;
            end
            out1_ready = ($urandom_range(2) != 0);
            out2_ready = ($urandom_range(1) != 0);
            reset      = ($urandom_range(63) == 0);
        end
        reset = 1'b0; in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic_routing();
        test_backpressure();
        test_stream_wrap();
        test_reset_mid();
        test_counters();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/demux_1_2_32bit.md
# demux_1_2_32bit

- Registered 1-to-2 word router for the datapath.
- Takes 32-bit words from one valid/ready source and steers each word, by a per-word `select` bit, into one of two buffered output streams.
- It is the splitting counterpart of the 2:1 32-bit selector `mux_2_1_32bit` (input 1 on `select`=0, input 2 on `select`=1).
- Sits between a shared result producer and two independent consumers, for example the write-back and store paths.

## Interface
Parameters:
- `WIDTH`, 32, data word width.
- `DEPTH`, 2, entries per output FIFO; power of two, ≥2.

Ports (one clock; reset is synchronous and active-high):
- `clk`  input  1  rising-edge clock.
- `reset`  input  1  synchronous, active-high.
- `in_valid`  input  1  source word present.
- `in_ready`  output  1  router accepts the word this cycle.
- `in_data`  input  WIDTH  source word.
- `select`  input  1  destination: 0 → out1, 1 → out2; sampled with `in_data`.
- `out1_valid`  output  1  out1 FIFO non-empty.
- `out1_ready`  input  1  out1 consumer takes head word.
- `out1_data`  output  WIDTH  out1 head word.
- `out2_valid`, `out2_ready`, `out2_data`: same as out1, for destination 2.
- `out1_count`  output  16  words delivered on out1 (see Configuration).
- `out2_count`  output  16  words delivered on out2 (see Configuration).

## Operation
- Two independent FIFOs, each DEPTH entries, with read pointer, write pointer and occupancy counter of width log2(DEPTH)+1.
- Accept (push) condition: `in_valid && in_ready`.
  - `in_ready` = `!full1` when `select`=0, `!full2` when `select`=1.
  - It is combinational from `select` and the registered full flags only, never from `out*_ready`.
- Push writes `in_data` to the selected FIFO only. The other FIFO is untouched.
- Pop on outN happens when `outN_valid && outN_ready`. It advances the read pointer.
- `outN_data` is the head entry. It holds its value while `outN_valid` is high and no pop occurs.
- Pointers wrap modulo DEPTH.
- Push and pop on the same FIFO in the same cycle: occupancy unchanged, both pointers advance.
- Full FIFO with a pop in the same cycle: `in_ready` stays 0 for that FIFO. There is no pass-through.
- Empty FIFO: `outN_valid`=0 and `outN_data` holds its last value. The consumer ignores it.
- Per-stream word order is preserved. There is no ordering guarantee between out1 and out2.
- `in_ready` may be 0 toward one destination while the other has space. The source must hold `in_valid`, `in_data` and `select` stable until accepted.

## Timing
- Reset (synchronous, `reset`=1 at a rising edge):
  - Both FIFOs are empty.
  - `out1_valid`=`out2_valid`=0, `out1_data`=`out2_data`=0.
  - Counts are 0.
  - `in_ready` is 1 for either select after reset.
- Reset mid-operation discards all buffered words. Pops asserted in the reset cycle are ignored.
- Latency: a word accepted at edge k has `outN_valid`=1 after edge k, and is available for pop in cycle k+1. There is no combinational in→out path.
- Throughput: 1 word/cycle per stream when the consumer pops every cycle (DEPTH≥2).
- Full flag is set when occupancy = DEPTH. Empty flag is set when occupancy = 0. Both are updated at the same edge as the push/pop.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - `out1_count`/`out2_count` increment by 1 on every pop of their stream.
  - They saturate at 16'hFFFF.
  - They clear on reset.
- Undefined: both count ports are tied to 16'h0000, and no counter registers are built.

## Test plan
- **Reset:** assert `reset` 2 cycles with `in_valid`=1 → both `outN_valid`=0, `outN_data`=0, counts 0, and no word captured.
- **Basic routing:**
  - Push 32'h55555AAA with `select`=0, then 32'hFFFFFFFF with `select`=1, both consumers ready.
  - Required: out1 shows 32'h55555AAA one cycle after its acceptance, out2 shows 32'hFFFFFFFF one cycle after its acceptance, and neither word appears on the other port.
- **Fill/backpressure:**
  - `out1_ready`=0, push 3 words to out1 (DEPTH=2).
  - Required: the third sees `in_ready`=0.
  - Then push to out2 → accepted immediately.
  - Release `out1_ready` → words pop in order, and the third is accepted the cycle after first pop frees space.
- **Simultaneous push/pop and wrap:** stream 10 words 1..10 to out2 with `out2_ready`=1 → out2 delivers 1..10 in order, one per cycle, and occupancy never exceeds 1.
- **Reset mid-stream:** with 2 words buffered in out1, pulse `reset` → `out1_valid`=0 next cycle, and subsequent words deliver in order starting fresh.
- **Counters (`DEMUX_COUNT_EN`):** deliver 5 words on out1 and 3 on out2 → `out1_count`=5, `out2_count`=3. Without the macro → both read 0.
